retrosoc_rst_seq: RTL



---
 rtl/retrosoc_rst_pkg.sv | 21 ++
 rtl/retrosoc_sync_debounce.sv | 61 ++++++
 rtl/retrosoc_rst_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/retrosoc_rst_pkg.sv
// Shared types and constants for the board-level reset sequencer.
package retrosoc_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RUN       = 2'd2
  } rst_state_t;

  // Encodings reported on rst_cause_o
  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_LOCK = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/retrosoc_sync_debounce.sv
// Multi-flop synchronizer followed by a stable-count debouncer.
// The debounced output only follows the synchronized input after it has
// differed from the current debounced value for DEBOUNCE_CYCLES cycles.
module retrosoc_sync_debounce
  import retrosoc_rst_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 100000,
  parameter logic RST_VAL         = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic db_o
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_s;
  logic                   db_reg, db_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;

  assign sync_s = sync_reg[SYNC_STAGES-1];
  assign db_o   = db_reg;

  // Synchronizer shift chain, bit 0 is the first flop after the pin
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_reg <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_i};
    end
  end

  // Count consecutive cycles of disagreement; commit on the terminal count
  always_comb begin
    db_next  = db_reg;
    cnt_next = '0;
    if (sync_s != db_reg) begin
      if (cnt_reg == CNT_LAST) begin
        db_next = sync_s;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Debouncer state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db_reg  <= RST_VAL;
      cnt_reg <= '0;
    end else begin
      db_reg  <= db_next;
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/retrosoc_rst_seq.sv
// Board-level reset sequencer: synchronizes PLL lock, debounces the reset
// button, stretches reset after both are good and records why the SoC was
// last put into reset.
// Optional watchdog: define RETROSOC_RST_WDT_EN to build the RUN-state
// watchdog kicked by rising edges on wdt_kick_i.
module retrosoc_rst_seq
  import retrosoc_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int HOLD_CYCLES     = 1024,
  parameter int WDT_CYCLES      = 2**24
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       btn_rst_n_i,
  input  logic       wdt_kick_i,
  output logic       soc_rst_n_o,
  output logic [1:0] rst_cause_o
);

  localparam int               HOLD_W    = cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] lock_sync_reg;
  logic                   locked_s;
  logic                   btn_db;
  logic                   wdt_expired;

  rst_state_t        state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              soc_rst_n_reg, soc_rst_n_next;
  logic [1:0]        cause_reg, cause_next;

  assign locked_s    = lock_sync_reg[SYNC_STAGES-1];
  assign soc_rst_n_o = soc_rst_n_reg;
  assign rst_cause_o = cause_reg;

  // Lock is synchronized only; a single low sample is enough to drop reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_sync_reg <= '0;
    end else begin
      lock_sync_reg <= {lock_sync_reg[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  retrosoc_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (1'b1)
  ) u_btn (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(btn_rst_n_i),
    .db_o   (btn_db)
  );

`ifdef RETROSOC_RST_WDT_EN
  localparam int              WDT_W    = cnt_width(WDT_CYCLES);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] kick_sync_reg;
  logic                   kick_prev_reg;
  logic                   kick_rise;
  logic [WDT_W-1:0]       wdt_cnt_reg, wdt_cnt_next;

  assign kick_rise   = kick_sync_reg[SYNC_STAGES-1] & ~kick_prev_reg;
  assign wdt_expired = (state_reg == RUN) && (wdt_cnt_reg == WDT_LAST);

  // Kick synchronizer plus the extra flop used for rising-edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kick_sync_reg <= '0;
      kick_prev_reg <= 1'b0;
    end else begin
      kick_sync_reg <= {kick_sync_reg[SYNC_STAGES-2:0], wdt_kick_i};
      kick_prev_reg <= kick_sync_reg[SYNC_STAGES-1];
    end
  end

  // Counter only advances while staying in RUN, so it is zero on RUN entry
  always_comb begin
    wdt_cnt_next = '0;
    if ((state_reg == RUN) && (state_next == RUN) && !kick_rise) begin
      wdt_cnt_next = wdt_cnt_reg + 1'b1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdt_cnt_reg <= '0;
    end else begin
      wdt_cnt_reg <= wdt_cnt_next;
    end
  end
`else
  // Watchdog not built: the kick pin is accepted but has no effect
  localparam int unused_wdt_cycles = WDT_CYCLES;
  logic          unused_kick;

  assign unused_kick = wdt_kick_i;
  assign wdt_expired = 1'b0;
`endif

  // Next-state logic; events are prioritized lock loss > button > watchdog
  always_comb begin
    state_next     = state_reg;
    hold_cnt_next  = '0;
    soc_rst_n_next = soc_rst_n_reg;
    cause_next     = cause_reg;
    case (state_reg)
      WAIT_LOCK: begin
        soc_rst_n_next = 1'b0;
        if (locked_s && btn_db) begin
          state_next = STRETCH;
        end
      end
      STRETCH: begin
        soc_rst_n_next = 1'b0;
        hold_cnt_next  = hold_cnt_reg + 1'b1;
        if (!locked_s) begin
          state_next    = WAIT_LOCK;
          cause_next    = CAUSE_LOCK;
          hold_cnt_next = '0;
        end else if (!btn_db) begin
          state_next    = WAIT_LOCK;
          cause_next    = CAUSE_BTN;
          hold_cnt_next = '0;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next     = RUN;
          soc_rst_n_next = 1'b1;
          hold_cnt_next  = '0;
        end
      end
      RUN: begin
        soc_rst_n_next = 1'b1;
        if (!locked_s) begin
          state_next     = WAIT_LOCK;
          cause_next     = CAUSE_LOCK;
          soc_rst_n_next = 1'b0;
        end else if (!btn_db) begin
          state_next     = WAIT_LOCK;
          cause_next     = CAUSE_BTN;
          soc_rst_n_next = 1'b0;
        end else if (wdt_expired) begin
          state_next     = WAIT_LOCK;
          cause_next     = CAUSE_WDT;
          soc_rst_n_next = 1'b0;
        end
      end
      default: begin
        state_next     = WAIT_LOCK;
        soc_rst_n_next = 1'b0;
      end
    endcase
  end

  // State, stretch counter, output flop and sticky cause
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= WAIT_LOCK;
      hold_cnt_reg  <= '0;
      soc_rst_n_reg <= 1'b0;
      cause_reg     <= CAUSE_POR;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      soc_rst_n_reg <= soc_rst_n_next;
      cause_reg     <= cause_next;
    end
  end

endmodule
